// File: rtl/sd_seq_check_if.sv
// Srdy/drdy handshake bundle between a producer (master) and the sequence checker (slave).
interface sd_seq_check_if #(
    parameter int unsigned width = 8
) ();
    logic             c_srdy;
    logic             c_drdy;
    logic [width-1:0] c_data;

    modport master (output c_srdy, output c_data, input c_drdy);
    modport slave  (input c_srdy, input c_data, output c_drdy);
endinterface

// File: rtl/sd_seq_check.sv
// Consumer-side srdy/drdy checker: accepts a programmed word count under a drdy pattern and
// checks each word against {tag_val, expected_count}, keeping error statistics.
module sd_seq_check #(
    parameter int unsigned        width    = 8,
    parameter int unsigned        tag_sz   = 1,
    parameter logic [tag_sz-1:0]  tag_val  = '0,
    parameter int unsigned        pat_dep  = 8,
    parameter logic [pat_dep-1:0] drdy_pat = '1
) (
    input  logic             clk,
    input  logic             reset,
    sd_seq_check_if.slave    c_if,
    input  logic             start,
    input  logic [31:0]      amount,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      err_count,
    output logic [31:0]      rx_count,
    output logic [width-1:0] bad_data
);
    localparam int unsigned count_sz = width - tag_sz;
    localparam int unsigned ptr_w    = (pat_dep > 1) ? $clog2(pat_dep) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [31:0]         rem_q, rem_d;
    logic [ptr_w-1:0]    ptr_q, ptr_d;
    logic [count_sz-1:0] exp_q, exp_d;
    logic                err_q, err_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [31:0]         rx_count_q, rx_count_d;
    logic [width-1:0]    bad_data_q, bad_data_d;
    logic                drdy;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        ptr_d       = ptr_q;
        exp_d       = exp_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        rx_count_d  = rx_count_q;
        bad_data_d  = bad_data_q;
        drdy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d       = 1'b0;
                    err_count_d = '0;
                    rx_count_d  = '0;
                    bad_data_d  = '0;
                    if (amount != 32'd0) begin
                        rem_d   = amount;
                        ptr_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                // drdy depends only on registered state, never on c_srdy
                drdy  = drdy_pat[ptr_q];
                ptr_d = (ptr_q == ptr_w'(pat_dep - 1)) ? '0 : ptr_q + ptr_w'(1);
                if (c_if.c_srdy && drdy) begin
                    rx_count_d = rx_count_q + 32'd1;
                    rem_d      = rem_q - 32'd1;
                    if (c_if.c_data == {tag_val, exp_q}) begin
                        exp_d = exp_q + count_sz'(1);
                    end else begin
                        err_d = 1'b1;
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                        if (!err_q) bad_data_d = c_if.c_data;
                        // Resync so a single dropped/duplicated word costs one error
                        exp_d = c_if.c_data[count_sz-1:0] + count_sz'(1);
                    end
                    if (rem_q == 32'd1) state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            ptr_q       <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            rx_count_q  <= '0;
            bad_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ptr_q       <= ptr_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            rx_count_q  <= rx_count_d;
            bad_data_q  <= bad_data_d;
        end
    end

    assign c_if.c_drdy = drdy;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign err         = err_q;
    assign err_count   = err_count_q;
    assign rx_count    = rx_count_q;
    assign bad_data    = bad_data_q;
endmodule

// File: doc/sd_seq_check.md
# sd_seq_check

Srdy/drdy sequence checker: the consumer-side counterpart to the team's incrementing-data sequence generator. It accepts a programmed number of words, throttles acceptance with a configurable drdy pattern, and checks each word against `{tag_val, expected_count}`. It reports completion, a sticky error flag, a saturating error count and the first bad word. It sits on the consumer end of any srdy/drdy block under test in the unit-level benches.

## Interface
- `width`, 8: data width.
- `tag_sz`, 1: tag field width; count field is `count_sz = width - tag_sz`.
- `tag_val`, 0: expected tag in `c_data[width-1:count_sz]`.
- `pat_dep`, 8: drdy pattern length, 1..32.
- `drdy_pat`, all ones: `pat_dep`-bit pattern; bit `ptr` set means drdy is asserted that cycle.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `c_srdy`  in  1  producer has valid data.
- `c_drdy`  out  1  checker accepts data this cycle.
- `c_data`  in  width  producer data.
- `start`  in  1  single-cycle pulse; begins a run (honoured in IDLE only).
- `amount`  in  32  words to accept; sampled with `start`.
- `busy`  out  1  high in RUN.
- `done`  out  1  single-cycle pulse at end of run.
- `err`  out  1  sticky; any mismatch since last `start`.
- `err_count`  out  16  mismatches since last `start`; saturates at 16'hFFFF.
- `rx_count`  out  32  words accepted since last `start`.
- `bad_data`  out  width  first mismatching word since last `start`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start` with `amount` != 0: `rem <= amount`, `ptr <= 0`; clear `err`, `err_count`, `rx_count`, `bad_data`; go to RUN.
  - `start` with `amount` == 0: clear the same stats and go directly to DONE.
- RUN:
  - `c_drdy = drdy_pat[ptr]`. This is a decode of registers only; there is no combinational path from `c_srdy`.
  - `ptr <= (ptr + 1) % pat_dep` every cycle in RUN.
  - Transfer occurs when `c_srdy & c_drdy`. On each transfer:
    - `rx_count` increments and `rem` decrements.
    - The received word is compared to `{tag_val, exp}`.
  - Match: `exp <= exp + 1`, wrapping modulo `2^count_sz`.
  - Mismatch:
    - `err <= 1` and `err_count` increments, saturating.
    - If this is the first mismatch of the run, `bad_data <= c_data`.
    - Resync: `exp <= c_data[count_sz-1:0] + 1`, so one dropped or duplicated word counts as a single error.
  - A transfer with `rem == 1` goes to DONE.
- DONE: `done = 1` for one cycle, then IDLE.
- `start` in RUN or DONE is ignored.
- `exp` is reset to 0 only by `reset`; it persists across runs, matching the generator's free-running count.
- `c_srdy` while not in RUN is not accepted and is not an error.

## Timing
- Reset values:
  - Outputs: `c_drdy=0`, `busy=0`, `done=0`, `err=0`, `err_count=0`, `rx_count=0`, `bad_data=0`.
  - Internal: state IDLE, `exp=0`, `ptr=0`, `rem=0`.
- Reset mid-run aborts at that edge. No `done` pulse is produced, and `c_drdy` is low in the following cycle.
- Run start:
  - `start` at edge N: `busy` and `c_drdy` (when `drdy_pat[0]`) are valid from edge N+1.
  - The earliest transfer completes at edge N+2.
- Run end:
  - Final transfer at edge M: `c_drdy=0` and `busy=0` after M.
  - `done` is high between M and M+1; the next `start` is accepted at edge M+2.
- Zero-amount run: `start` at N gives `done` high between N+1 and N+2, with `c_drdy` never asserted.
- Statistics update on the same edge as the transfer.
- The wrap from `exp = 2^count_sz - 1` to 0 is a match, not an error.

## Test plan
- Defaults, generator with all-ones pattern, `amount=20`, data 0..19 with tag 0 -> 20 transfers back-to-back, `done` 1 cycle after the 20th, `err=0`, `rx_count=20`.
- Pattern `drdy_pat=8'b1010_0110`, `amount=16`, generator sends 16 words -> `c_drdy` follows the pattern from `ptr=0`; all words checked, `err=0`, next `exp=16`.
- Word 5 dropped (sequence 0..4, 6..10), `amount=10` -> `err=1`, `err_count=1`, `bad_data=8'h06`, `done` asserted.
- `width=8`, `tag_sz=1`, 130 words starting at count 120 (`exp` preloaded by a prior run of 120) -> wrap 127 to 0 accepted, `err_count=0`.
- Wrong tag (`tag_val=1` expected, producer sends tag 0), `amount=4` -> `err_count=4`, `bad_data` equal to the first word.
- Edge cases:
  - `amount=0` -> `done` pulse, no drdy.
  - `reset` after 3 of 10 words -> all outputs reset, no `done`.
  - `start` pulsed during RUN -> ignored.
